// File: rtl/dcache_pkg.sv
// Shared configuration, bus types and array-port types for the data cache.
// The index/tag widths of the array ports follow configure::dcache_depth.
package configure;
  localparam int          dcache_depth = 6;
  localparam logic [31:0] dcache_base  = 32'h80000000;
endpackage

package dcache_wires;
  localparam int IDX_W = configure::dcache_depth;
  localparam int TAG_W = 28 - configure::dcache_depth;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  // wen writes one word under wstrb; wvalid also writes wtag (line becomes complete)
  typedef struct packed {
    logic             wen;
    logic [IDX_W-1:0] windex;
    logic [TAG_W-1:0] wtag;
    logic             wvalid;
    logic [1:0]       wword;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic [IDX_W-1:0] rindex;
  } dcache_data_in_type;

  typedef struct packed {
    logic [TAG_W-1:0] rtag;
    logic [127:0]     rline;
  } dcache_data_out_type;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    REFILL,
    RESP,
    WRITE,
    UNCACHED,
    FENCE
  } dcache_state_t;

  function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] word);
    return line[{word, 5'b00000} +: 32];
  endfunction
endpackage

// File: rtl/dcache_data.sv
// Tag and data arrays of the data cache: combinational read port,
// byte-strobed synchronous write port, no reset.
module dcache_data
  import dcache_wires::*;
#(
  parameter int dcache_depth = configure::dcache_depth
) (
  input  logic                clock,
  input  dcache_data_in_type  i_data,
  output dcache_data_out_type o_data
);
  localparam int LINES = 1 << dcache_depth;

  logic [TAG_W-1:0] r_tag  [LINES];
  logic [127:0]     r_data [LINES];

  always_ff @(posedge clock) begin
    if (i_data.wvalid) begin
      r_tag[i_data.windex] <= i_data.wtag;
    end
    if (i_data.wen) begin
      for (int b = 0; b < 4; b++) begin
        if (i_data.wstrb[b]) begin
          r_data[i_data.windex][{i_data.wword, b[1:0], 3'b000} +: 8] <= i_data.wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_data.rtag  = r_tag[i_data.rindex];
  assign o_data.rline = r_data[i_data.rindex];
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// One request is in flight at a time; uncached and fence requests pass to backing memory.
module dcache
  import dcache_wires::*;
#(
  parameter int          dcache_depth = configure::dcache_depth,
  parameter logic [31:0] dcache_base  = configure::dcache_base
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  dcache_in,
  output mem_out_type dcache_out,
  output mem_in_type  dmem_in,
  input  mem_out_type dmem_out
);
  localparam int LINES = 1 << dcache_depth;

  dcache_state_t            r_state, w_nextState;
  logic [31:0]              r_addr;
  logic [31:0]              r_wdata;
  logic [3:0]               r_wstrb;
  logic [1:0]               r_beat, w_beatNext;
  logic                     r_issued, w_issuedNext;
  logic                     r_cleared, w_clearedNext;
  logic [LINES-1:0]         r_valid;
  logic                     w_setValid, w_clearValid;
  logic [dcache_depth-1:0]  w_index;
  logic [27-dcache_depth:0] w_tag;
  logic [1:0]               w_offset;
  logic                     w_store, w_hit;
  logic [31:0]              w_word;
  dcache_data_in_type       w_dataIn;
  dcache_data_out_type      w_dataOut;
  logic                     w_unused;

  assign w_index  = r_addr[dcache_depth+3:4];
  assign w_tag    = r_addr[31:dcache_depth+4];
  assign w_offset = r_addr[3:2];
  assign w_store  = |r_wstrb;
  assign w_hit    = r_valid[w_index] && (w_dataOut.rtag == w_tag);
  assign w_word   = sel_word(w_dataOut.rline, w_offset);
  assign w_unused = dcache_in.mem_instr;

  dcache_data #(
    .dcache_depth(dcache_depth)
  ) u_data (
    .clock (clock),
    .i_data(w_dataIn),
    .o_data(w_dataOut)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_beat    <= '0;
      r_issued  <= 1'b0;
      r_cleared <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_beat    <= w_beatNext;
      r_issued  <= w_issuedNext;
      r_cleared <= w_clearedNext;
      if (r_state == IDLE && dcache_in.mem_valid) begin
        r_addr  <= dcache_in.mem_addr;
        r_wdata <= dcache_in.mem_wdata;
        r_wstrb <= dcache_in.mem_wstrb;
      end
    end
  end

  // Valid bits live outside the arrays so reset and fence can clear them in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (w_clearValid) begin
      r_valid <= '0;
    end else if (w_setValid) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_beatNext      = r_beat;
    w_issuedNext    = r_issued;
    w_clearedNext   = r_cleared;
    w_setValid      = 1'b0;
    w_clearValid    = 1'b0;
    dcache_out      = '0;
    dmem_in         = '0;
    w_dataIn        = '0;
    w_dataIn.windex = w_index;
    w_dataIn.wtag   = w_tag;
    w_dataIn.rindex = (r_state == IDLE) ? dcache_in.mem_addr[dcache_depth+3:4] : w_index;

    case (r_state)
      IDLE: begin
        if (dcache_in.mem_valid) begin
          w_beatNext    = '0;
          w_issuedNext  = 1'b0;
          w_clearedNext = 1'b0;
          if (dcache_in.mem_fence) begin
            w_nextState = FENCE;
          end else if (dcache_in.mem_addr < dcache_base) begin
            w_nextState = UNCACHED;
          end else begin
            w_nextState = COMPARE;
          end
        end
      end

      COMPARE: begin
        if (!w_store) begin
          if (w_hit) begin
            dcache_out.mem_ready = 1'b1;
            dcache_out.mem_rdata = w_word;
            w_nextState          = IDLE;
          end else begin
            w_nextState = REFILL;
          end
        end else begin
          w_dataIn.wen   = w_hit;
          w_dataIn.wword = w_offset;
          w_dataIn.wdata = r_wdata;
          w_dataIn.wstrb = r_wstrb;
          w_nextState    = WRITE;
        end
      end

      // Each beat: one request pulse, then wait for the word and store it.
      REFILL: begin
        dmem_in.mem_addr = {r_addr[31:4], r_beat, 2'b00};
        if (!r_issued) begin
          dmem_in.mem_valid = 1'b1;
          w_issuedNext      = 1'b1;
        end else if (dmem_out.mem_ready) begin
          w_dataIn.wen   = 1'b1;
          w_dataIn.wword = r_beat;
          w_dataIn.wdata = dmem_out.mem_rdata;
          w_dataIn.wstrb = 4'hF;
          w_issuedNext   = 1'b0;
          w_beatNext     = r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            w_dataIn.wvalid = 1'b1;
            w_setValid      = 1'b1;
            w_nextState     = RESP;
          end
        end
      end

      RESP: begin
        dcache_out.mem_ready = 1'b1;
        dcache_out.mem_rdata = w_word;
        w_nextState          = IDLE;
      end

      WRITE, UNCACHED: begin
        dmem_in.mem_addr  = r_addr;
        dmem_in.mem_wdata = r_wdata;
        dmem_in.mem_wstrb = r_wstrb;
        if (!r_issued) begin
          dmem_in.mem_valid = 1'b1;
          w_issuedNext      = 1'b1;
        end else if (dmem_out.mem_ready) begin
          dcache_out.mem_ready = 1'b1;
          if (r_state == UNCACHED) begin
            dcache_out.mem_rdata = dmem_out.mem_rdata;
          end
          w_nextState = IDLE;
        end
      end

      FENCE: begin
        if (!r_cleared) begin
          w_clearValid  = 1'b1;
          w_clearedNext = 1'b1;
        end else begin
          dmem_in.mem_fence = 1'b1;
          dmem_in.mem_addr  = r_addr;
          if (!r_issued) begin
            dmem_in.mem_valid = 1'b1;
            w_issuedNext      = 1'b1;
          end else if (dmem_out.mem_ready) begin
            dcache_out.mem_ready = 1'b1;
            w_nextState          = IDLE;
          end
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed and randomized requests checked against a
// line-level cache model plus a backing-memory stub with random response latency.
module tb_dcache;
  import dcache_wires::*;

  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          LINES = 64;

  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memOp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  dcache_in;
  mem_out_type dcache_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] memory [logic [29:0]];
  bit          mValid [LINES];
  logic [21:0] mTag [LINES];
  logic [31:0] mLine [LINES][4];

  memOp_t      expOps[$];
  logic [31:0] expRdata;
  bit          checkRdata;
  int          expLatency;
  bit          txnActive = 1'b0;
  int          respSeen = 0;
  int          acceptCycle = 0;
  int          cycleCnt = 0;
  int          dmemCount = 0;
  bit          outstanding = 1'b0;
  logic [31:0] lastRdata = '0;
  int          lastLatency = 0;

  dcache #(
    .dcache_depth(6),
    .dcache_base (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .dcache_in (dcache_in),
    .dcache_out(dcache_out),
    .dmem_in   (dmem_in),
    .dmem_out  (dmem_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: condition not met at cycle %0d", name, cycleCnt);
  endtask

  // Unwritten memory reads as the inverted word address, so expected values are easy to derive.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memory.exists(a[31:2])) return memory[a[31:2]];
    return ~{a[31:2], 2'b00};
  endfunction

  task automatic memWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w;
    w = memRead(a);
    for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
    memory[a[31:2]] = w;
  endtask

  task automatic clearModel();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
  endtask

  // What the cache must do for one request, from the line-level view of the cache.
  task automatic predict(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb, input bit fence);
    int idx;
    int off;
    logic [21:0] tag;
    logic [31:0] a;
    idx = int'(addr[9:4]);
    off = int'(addr[3:2]);
    tag = addr[31:10];
    expOps.delete();
    checkRdata = 1'b1;
    expLatency = 0;
    expRdata   = '0;
    if (fence) begin
      clearModel();
      expOps.push_back('{fence: 1'b1, addr: addr, wdata: 32'h0, wstrb: 4'h0});
      checkRdata = 1'b0;
    end else if (addr < BASE) begin
      expOps.push_back('{fence: 1'b0, addr: addr, wdata: wdata, wstrb: wstrb});
      expRdata = memRead(addr);
    end else if (wstrb == 4'h0) begin
      if (mValid[idx] && mTag[idx] == tag) begin
        expLatency = 1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          a = {addr[31:4], 4'h0} + 32'(k * 4);
          expOps.push_back('{fence: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0});
          mLine[idx][k] = memRead(a);
        end
        mValid[idx] = 1'b1;
        mTag[idx]   = tag;
      end
      expRdata = mLine[idx][off];
    end else begin
      if (mValid[idx] && mTag[idx] == tag) begin
        for (int b = 0; b < 4; b++) if (wstrb[b]) mLine[idx][off][b*8 +: 8] = wdata[b*8 +: 8];
      end
      expOps.push_back('{fence: 1'b0, addr: addr, wdata: wdata, wstrb: wstrb});
    end
  endtask

  // Backing memory: answers each request 1..3 cycles later with a one-cycle ready.
  initial begin
    mem_in_type req;
    int  lat;
    bit  aborted;
    dmem_out = '0;
    forever begin
      @(negedge clock);
      if (reset && dmem_in.mem_valid) begin
        req = dmem_in;
        lat = int'($urandom_range(1, 3));
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clock);
          if (!reset) aborted = 1'b1;
        end
        if (!aborted) begin
          #1;
          dmem_out.mem_ready = 1'b1;
          dmem_out.mem_rdata = req.mem_fence ? 32'h0 : memRead(req.mem_addr);
          if (!req.mem_fence && req.mem_wstrb != 4'h0) memWrite(req.mem_addr, req.mem_wdata, req.mem_wstrb);
          @(posedge clock);
          #1;
          dmem_out = '0;
        end
      end
    end
  end

  // Per-cycle compare process.
  always @(negedge clock) begin
    memOp_t op;
    if (!reset) begin
      checkOutput("outputs_in_reset", {dcache_out, dmem_in}, '0);
      outstanding = 1'b0;
    end else begin
      checkOutput("dmem_instr_zero", dmem_in.mem_instr, 1'b0);
      if (!dcache_out.mem_ready) checkOutput("rdata_zero_without_ready", dcache_out.mem_rdata, 32'h0);
      if (dmem_in.mem_valid) checkOutput("dmem_valid_while_waiting", outstanding, 1'b0);
      if (dmem_out.mem_ready) outstanding = 1'b0;
      if (dmem_in.mem_valid) begin
        outstanding = 1'b1;
        dmemCount++;
        if (expOps.size() == 0) begin
          flagFail("unexpected_dmem_request");
        end else begin
          op = expOps.pop_front();
          checkOutput("dmem_fence", dmem_in.mem_fence, op.fence);
          if (!op.fence) begin
            checkOutput("dmem_addr", dmem_in.mem_addr, op.addr);
            checkOutput("dmem_wstrb", dmem_in.mem_wstrb, op.wstrb);
            if (op.wstrb != 4'h0) checkOutput("dmem_wdata", dmem_in.mem_wdata, op.wdata);
          end
        end
      end
      if (dcache_out.mem_ready) begin
        lastRdata   = dcache_out.mem_rdata;
        lastLatency = cycleCnt - acceptCycle + 1;
        if (!txnActive || respSeen != 0) begin
          flagFail("extra_ready");
        end else begin
          respSeen = 1;
          if (checkRdata) checkOutput("rdata", dcache_out.mem_rdata, expRdata);
          if (expLatency > 0) checkOutput("hit_latency", 32'(lastLatency), 32'(expLatency));
          checkOutput("dmem_ops_before_ready", 32'(expOps.size()), 32'h0);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb, input bit fence);
    predict(addr, wdata, wstrb, fence);
    respSeen  = 0;
    txnActive = 1'b1;
    @(negedge clock);
    dcache_in.mem_valid = 1'b1;
    dcache_in.mem_fence = fence;
    dcache_in.mem_instr = 1'b0;
    dcache_in.mem_addr  = addr;
    dcache_in.mem_wdata = wdata;
    dcache_in.mem_wstrb = wstrb;
    @(posedge clock);
    #1;
    acceptCycle = cycleCnt;
    dcache_in = '0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                               input bit fence, output int dmemDelta);
    int start;
    int n;
    start = dmemCount;
    issue(addr, wdata, wstrb, fence);
    n = 0;
    while (respSeen == 0 && n < 80) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (respSeen == 0) flagFail("response_timeout");
    @(negedge clock);
    #1;
    checkOutput("dmem_ops_left", 32'(expOps.size()), 32'h0);
    expOps.delete();
    txnActive = 1'b0;
    dmemDelta = dmemCount - start;
  endtask

  initial begin
    int d;
    int n;
    int start;
    logic [31:0] addr;
    logic [3:0]  strb;
    dcache_in = '0;
    clearModel();
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_state", {dcache_out, dmem_in}, '0);
    reset = 1'b1;

    applyStimulus(32'h80000010, 32'h0, 4'h0, 1'b0, d);
    checkOutput("cold_load_beats", 32'(d), 32'd4);
    checkOutput("cold_load_data", lastRdata, 32'h7FFFFFEF);
    applyStimulus(32'h80000010, 32'h0, 4'h0, 1'b0, d);
    checkOutput("warm_load_no_traffic", 32'(d), 32'd0);
    checkOutput("warm_load_latency", 32'(lastLatency), 32'd1);
    checkOutput("warm_load_data", lastRdata, 32'h7FFFFFEF);

    applyStimulus(32'h80000014, 32'hAABBCCDD, 4'h3, 1'b0, d);
    checkOutput("store_hit_one_write", 32'(d), 32'd1);
    checkOutput("store_rdata_zero", lastRdata, 32'h0);
    applyStimulus(32'h80000014, 32'h0, 4'h0, 1'b0, d);
    checkOutput("merged_load_no_traffic", 32'(d), 32'd0);
    checkOutput("merged_load_data", lastRdata, 32'h7FFFCCDD);

    applyStimulus(32'h80001000, 32'h11223344, 4'hF, 1'b0, d);
    checkOutput("store_miss_one_write", 32'(d), 32'd1);
    applyStimulus(32'h80001000, 32'h0, 4'h0, 1'b0, d);
    checkOutput("no_allocate_refill", 32'(d), 32'd4);
    checkOutput("no_allocate_data", lastRdata, 32'h11223344);

    applyStimulus(32'h10000000, 32'h0, 4'h0, 1'b0, d);
    checkOutput("uncached_forward", 32'(d), 32'd1);
    checkOutput("uncached_data", lastRdata, 32'hEFFFFFFF);
    applyStimulus(32'h10000000, 32'h0, 4'h0, 1'b0, d);
    checkOutput("uncached_again", 32'(d), 32'd1);

    applyStimulus(32'h80000000, 32'h0, 4'h0, 1'b1, d);
    checkOutput("fence_one_request", 32'(d), 32'd1);
    applyStimulus(32'h80000010, 32'h0, 4'h0, 1'b0, d);
    checkOutput("reload_after_fence", 32'(d), 32'd4);
    checkOutput("reload_after_fence_data", lastRdata, 32'h7FFFFFEF);

    start = dmemCount;
    issue(32'h80000030, 32'h0, 4'h0, 1'b0);
    n = 0;
    while (dmemCount < start + 3 && n < 80) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (dmemCount < start + 3) flagFail("refill_beat2_timeout");
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {dcache_out, dmem_in}, '0);
    expOps.delete();
    txnActive = 1'b0;
    clearModel();
    repeat (2) @(negedge clock);
    checkOutput("no_response_after_abort", 32'(respSeen), 32'd0);
    reset = 1'b1;
    applyStimulus(32'h80000030, 32'h0, 4'h0, 1'b0, d);
    checkOutput("refill_after_reset", 32'(d), 32'd4);
    checkOutput("refill_after_reset_data", lastRdata, 32'h7FFFFFCF);

    for (int t = 0; t < 250; t++) begin
      n = int'($urandom_range(0, 11));
      strb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (n == 0) begin
        applyStimulus(BASE, 32'h0, 4'h0, 1'b1, d);
      end else if (n == 1) begin
        addr = 32'h10000000 + 32'($urandom_range(0, 7) * 4);
        applyStimulus(addr, $urandom, strb, 1'b0, d);
      end else begin
        addr = BASE | 32'($urandom_range(0, 2) << 10) | 32'($urandom_range(0, 3) << 4)
                    | 32'($urandom_range(0, 3) << 2);
        applyStimulus(addr, $urandom, strb, 1'b0, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] global timeout");
  end
endmodule
